// File: rtl/uart_rx_controller.sv
// UART receive controller: captures receiver bytes into a show-ahead
// FIFO for the host, with RTS flow control and a line timeout.
module uart_rx_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int RTS_THRESHOLD  = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_data_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_parity_ok,
  input  logic                          rx_receiving,
  input  logic                          handshake_en,
  input  logic                          host_read,
  input  logic                          overrun_clr,
  output logic                          rx_data_ack,
  output logic                          rx_timeout,
  output logic                          rts_n,
  output logic                          host_valid,
  output logic [7:0]                    host_data,
  output logic                          host_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ACK
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_nxt;
  logic [CW-1:0]   count_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [8:0]      wdata;
  logic [8:0]      head_nxt;
  logic            full;
  logic            pop;
  logic            capture;
  logic            wr_en;
  logic            drop;

  assign wdata       = {~rx_parity_ok, rx_data};
  assign full        = (fifo_count == CW'(FIFO_DEPTH));
  assign pop         = host_read & host_valid;
  assign capture     = (state == CAPTURE);
  assign wr_en       = capture & (~full | pop);
  assign drop        = capture & full & ~pop;
  assign rx_data_ack = (state == ACK);
  assign host_valid  = (fifo_count != '0);

  // capture FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // capture FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rx_data_ready) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     if (!rx_data_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next head pointer, count and head entry (bypass a same-cycle write)
  always_comb begin
    rd_nxt    = rd_ptr;
    count_nxt = fifo_count;
    if (pop) rd_nxt = rd_ptr + AW'(1);
    if (wr_en && !pop) count_nxt = fifo_count + CW'(1);
    if (!wr_en && pop) count_nxt = fifo_count - CW'(1);
    if (wr_en && (rd_nxt == wr_ptr)) head_nxt = wdata;
    else                             head_nxt = mem[rd_nxt];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // FIFO pointers, count, show-ahead head register and overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      host_data       <= '0;
      host_parity_err <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nxt;
      fifo_count <= count_nxt;
      if (count_nxt != '0) begin
        host_data       <= head_nxt[7:0];
        host_parity_err <= head_nxt[8];
      end
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  // RTS follows the registered fill level
  always_ff @(posedge clk) begin
    if (reset) rts_n <= 1'b0;
    else       rts_n <= handshake_en & (fifo_count >= CW'(RTS_THRESHOLD));
  end

  // receive timeout counter, re-arms after each pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt    <= '0;
      rx_timeout <= 1'b0;
    end else if (!rx_receiving) begin
      tmo_cnt    <= '0;
      rx_timeout <= 1'b0;
    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_cnt    <= '0;
      rx_timeout <= 1'b1;
    end else begin
      tmo_cnt    <= tmo_cnt + TW'(1);
      rx_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: vector table plus
// directed sequences for reset, overrun, flow control and timeout.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_parity_ok;
  logic       rx_receiving;
  logic       handshake_en;
  logic       host_read;
  logic       overrun_clr;
  logic       rx_data_ack;
  logic       rx_timeout;
  logic       rts_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_parity_err;
  logic [3:0] fifo_count;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rdy;
    logic [7:0] d;
    logic       ok;
    logic       rd;
    logic       e_ack;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_perr;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs [10];

  uart_rx_controller #(
    .FIFO_DEPTH(8),
    .RTS_THRESHOLD(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data_ready(rx_data_ready),
    .rx_data(rx_data),
    .rx_parity_ok(rx_parity_ok),
    .rx_receiving(rx_receiving),
    .handshake_en(handshake_en),
    .host_read(host_read),
    .overrun_clr(overrun_clr),
    .rx_data_ack(rx_data_ack),
    .rx_timeout(rx_timeout),
    .rts_n(rts_n),
    .host_valid(host_valid),
    .host_data(host_data),
    .host_parity_err(host_parity_err),
    .fifo_count(fifo_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ok);
    bit got;
    got = 1'b0;
    rx_data       = d;
    rx_parity_ok  = ok;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rx_data_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      bad++;
      total++;
      $display("FAIL ack_timeout: got 0 want 1");
    end
    rx_data_ready = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, host_valid, 1);
    chk({nm, "_data"}, host_data, exp);
    host_read = 1'b1;
    tick();
    host_read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && host_valid; i++) begin
      host_read = 1'b1;
      tick();
      host_read = 1'b0;
    end
    chk("drain_empty", host_valid, 0);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_ack"}, rx_data_ack, 0);
    chk({nm, "_tmo"}, rx_timeout, 0);
    chk({nm, "_rts"}, rts_n, 0);
    chk({nm, "_valid"}, host_valid, 0);
    chk({nm, "_data"}, host_data, 0);
    chk({nm, "_perr"}, host_parity_err, 0);
    chk({nm, "_cnt"}, fifo_count, 0);
    chk({nm, "_ovr"}, overrun, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd1};
    vecs[2] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd1};
    vecs[3] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0};
    vecs[7] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 4'd1};
    vecs[8] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 4'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 4'd0};

    reset         = 1'b1;
    rx_data_ready = 1'b0;
    rx_data       = 8'h00;
    rx_parity_ok  = 1'b1;
    rx_receiving  = 1'b0;
    handshake_en  = 1'b0;
    host_read     = 1'b0;
    overrun_clr   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("por");

    // reset mid-ACK with three bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("pre_rst_cnt", fifo_count, 3);
    rx_data       = 8'h44;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 8 && !rx_data_ack; i++) tick();
    chk("pre_rst_ack", rx_data_ack, 1);
    reset         = 1'b1;
    rx_data_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("midrst");

    // single byte sequences from the vector table
    for (int i = 0; i < 10; i++) begin
      rx_data_ready = vecs[i].rdy;
      rx_data       = vecs[i].d;
      rx_parity_ok  = vecs[i].ok;
      host_read     = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_ack", i), rx_data_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_valid", i), host_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), host_data, vecs[i].e_data);
      chk($sformatf("v%0d_perr", i), host_parity_err, vecs[i].e_perr);
      chk($sformatf("v%0d_cnt", i), fifo_count, vecs[i].e_cnt);
    end
    host_read     = 1'b0;
    rx_data_ready = 1'b0;
    rx_parity_ok  = 1'b1;

    // fill and overrun
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    chk("fill_cnt", fifo_count, 8);
    chk("fill_ovr", overrun, 1);
    rx_data       = 8'h0A;
    rx_data_ready = 1'b1;
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_wins_clr", overrun, 1);
    chk("ovr_cnt", fifo_count, 8);
    chk("ovr_ack", rx_data_ack, 1);
    rx_data_ready = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) pop_check($sformatf("fill_rd%0d", i), 8'(i));
    chk("fill_empty", host_valid, 0);
    chk("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // flow control
    handshake_en = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 1'b1);
    chk("fc_cnt5", fifo_count, 5);
    chk("fc_rts5", rts_n, 0);
    rx_data       = 8'h25;
    rx_data_ready = 1'b1;
    tick();
    tick();
    chk("fc_cnt6", fifo_count, 6);
    chk("fc_rts_lag", rts_n, 0);
    rx_data_ready = 1'b0;
    tick();
    chk("fc_rts_on", rts_n, 1);
    host_read = 1'b1;
    tick();
    host_read = 1'b0;
    chk("fc_cnt_rd", fifo_count, 5);
    chk("fc_rts_hold", rts_n, 1);
    tick();
    chk("fc_rts_off", rts_n, 0);
    send_byte(8'h26, 1'b1);
    chk("fc_rts_on2", rts_n, 1);
    handshake_en = 1'b0;
    tick();
    chk("fc_hs_off", rts_n, 0);
    send_byte(8'h27, 1'b1);
    send_byte(8'h28, 1'b1);
    chk("fc_cnt8", fifo_count, 8);
    chk("fc_rts_full", rts_n, 0);
    drain();

    // simultaneous write and pop when full
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
    chk("sim_full", fifo_count, 8);
    rx_data       = 8'h3C;
    rx_data_ready = 1'b1;
    tick();
    host_read = 1'b1;
    tick();
    host_read = 1'b0;
    chk("sim_cnt", fifo_count, 8);
    chk("sim_ovr", overrun, 0);
    chk("sim_head", host_data, 8'h11);
    rx_data_ready = 1'b0;
    tick();
    for (int i = 1; i < 8; i++)
      pop_check($sformatf("sim_rd%0d", i), 8'h10 + 8'(i));
    pop_check("sim_last", 8'h3C);
    chk("sim_empty", host_valid, 0);
    send_byte(8'h77, 1'b0);
    chk("par_head", host_data, 8'h77);
    chk("par_err", host_parity_err, 1);
    pop_check("par_rd", 8'h77);

    // timeout on a stuck line
    rx_receiving = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("tmo_c%0d", k), rx_timeout, (k == 16 || k == 32));
    end
    rx_receiving = 1'b0;
    tick();
    chk("tmo_low", rx_timeout, 0);
    rx_receiving = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rx_receiving = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("tmo_short%0d", k), rx_timeout, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
